led_pattern_gen: RTL
====================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 16, meaning the number of LED outputs; legal range 2 to 32.
REQ-002 Parameter STEP_DIV, default 300000, meaning clock cycles per pattern step; must be >= 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode  input  2  requested pattern: 0 BOUNCE, 1 ROTATE, 2 COUNT, 3 FILL.
REQ-006 mode_load  input  1  single-cycle strobe that latches mode and restarts the pattern.
REQ-007 pause  input  1  while high, the pattern and the prescaler freeze.
REQ-008 leds  output  WIDTH  current pattern, 1 = LED on; registered; feeds the PMOD LED driver directly.
REQ-009 step  output  1  one-cycle pulse, high in the same cycle that leds first shows a new step value.
REQ-010 mode_cur  output  2  mode currently in effect.

Function
REQ-011 Prescaler: down-counter; reload value STEP_DIV-1; decrements each cycle while pause=0.
REQ-012 When the prescaler reaches 0, it shall reload to STEP_DIV-1 and raise an internal tick, which advances leds by one step.
REQ-013 With pause=0, leds shall update exactly every STEP_DIV cycles; the first update comes STEP_DIV cycles after rst or mode_load deasserts.
REQ-014 With pause=1, the prescaler, leds, direction and phase shall hold and step shall be 0; counting resumes from the held prescaler value.
REQ-015 BOUNCE: one-hot pattern with an internal direction bit (initially left).
- Left: leds shifts left by 1 per tick.
- Right: leds shifts right by 1 per tick.
- When leds[WIDTH-1]=1, direction becomes right; when leds[0]=1, direction becomes left.
- The end bits are not repeated: for WIDTH=4 the sequence is 1,2,4,8,4,2,1,2,...
REQ-016 ROTATE: leds rotates left by 1 per tick; bit WIDTH-1 wraps to bit 0.
REQ-017 COUNT: leds increments by 1 per tick, modulo 2^WIDTH; all ones wraps to 0.
REQ-018 FILL: an internal phase bit selects fill or drain.
- Fill: leds = (leds<<1)|1 per tick; on reaching all ones, phase becomes drain.
- Drain: leds = leds>>1 per tick; on reaching 0, phase becomes fill.
- WIDTH=4 sequence: 0,1,3,7,F,7,3,1,0,1,...
REQ-019 mode_load shall, in the cycle after it is sampled high:
- set mode_cur to mode;
- load the mode's initial leds value: BOUNCE 1, ROTATE 1, COUNT 0, FILL 0;
- set direction to left and phase to fill;
- reload the prescaler to STEP_DIV-1;
- keep step at 0.
REQ-020 mode_load shall take priority over a coincident tick; that tick is discarded.
REQ-021 mode_load shall take effect even while pause=1; the pattern then stays frozen at the initial value.
REQ-022 Reloading the same mode as mode_cur shall still restart the pattern.
REQ-023 Whenever mode_cur is BOUNCE or ROTATE, leds shall always be one-hot.
REQ-024 No combinational path shall exist from any input to any output.

Reset
REQ-025 While rst=1, the block shall hold:
- leds = 1 (one-hot bit 0), mode_cur = 0, direction = left, phase = fill;
- prescaler = STEP_DIV-1, step = 0.
REQ-026 rst shall override mode_load and pause.
REQ-027 Reset asserted mid-step shall discard any partial prescaler count.

Verification (WIDTH=4, STEP_DIV=4)
REQ-028 Reset release, mode 0, pause=0.
- Expected leds: 1,2,4,8,4,2,1,2.
- Each change is 4 cycles apart and coincides with step=1.
REQ-029 Load mode=2 (COUNT), run 17 steps.
- Expected leds: 0,1,...,F,0.
- Wrap occurs at step 16, with mode_cur=2 throughout.
REQ-030 Load mode=3 (FILL), run 9 steps.
- Expected leds: 0,1,3,7,F,7,3,1,0, then 1.
REQ-031 Mode 1 (ROTATE): hold pause=1 for 10 cycles after leds=8, then release.
- leds holds 8 and step stays 0 during the pause.
- After release, leds becomes 1 after the remaining prescaler count completes.
REQ-032 Assert mode_load (mode=1) in the same cycle as a tick.
- Next cycle: leds=1, step=0, mode_cur=1.
- The next update (to 2) comes 4 cycles later.
REQ-033 Assert rst mid-BOUNCE, while leds=4 and moving right.
- Next cycle: leds=1, direction left, mode_cur=0.
- After release, the next update (to 2) comes 4 cycles later.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce, rotate, count and fill patterns advanced by a
// free-running prescaler, with pause, restartable mode load and registered outputs.
module led_pattern_gen #(
   parameter int WIDTH    = 16,
   parameter int STEP_DIV = 300000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             mode_load,
   input  logic             pause,
   output logic [WIDTH-1:0] leds,
   output logic             step,
   output logic [1:0]       mode_cur
);

   localparam int unsigned CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      BOUNCE = 2'd0,
      ROTATE = 2'd1,
      COUNT  = 2'd2,
      FILL   = 2'd3
   } mode_t;

   mode_t            mode_q;
   logic [CW-1:0]    cnt;
   logic             dir_right;
   logic             drain;
   logic [WIDTH-1:0] next_leds;
   logic             next_dir;
   logic             next_drain;
   logic [WIDTH-1:0] init_leds;
   logic             tick;

   assign mode_cur = mode_q;
   assign tick     = (cnt == '0);

   // Direction/phase turn on the end values themselves, so ends are never repeated.
   always_comb begin
      next_leds  = leds;
      next_dir   = dir_right;
      next_drain = drain;
      case (mode_q)
         BOUNCE: begin
            if (leds[WIDTH-1])
               next_dir = 1'b1;
            else if (leds[0])
               next_dir = 1'b0;
            next_leds = next_dir ? (leds >> 1) : (leds << 1);
         end
         ROTATE: next_leds = {leds[WIDTH-2:0], leds[WIDTH-1]};
         COUNT:  next_leds = leds + WIDTH'(1);
         FILL: begin
            if (leds == '1)
               next_drain = 1'b1;
            else if (leds == '0)
               next_drain = 1'b0;
            next_leds = next_drain ? (leds >> 1) : ((leds << 1) | WIDTH'(1));
         end
         default: next_leds = leds;
      endcase
   end

   always_comb begin
      init_leds = '0;
      if (mode_t'(mode) == BOUNCE || mode_t'(mode) == ROTATE)
         init_leds = WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         leds      <= WIDTH'(1);
         mode_q    <= BOUNCE;
         dir_right <= 1'b0;
         drain     <= 1'b0;
         cnt       <= RELOAD;
         step      <= 1'b0;
      end else if (mode_load) begin
         leds      <= init_leds;
         mode_q    <= mode_t'(mode);
         dir_right <= 1'b0;
         drain     <= 1'b0;
         cnt       <= RELOAD;
         step      <= 1'b0;
      end else if (pause) begin
         step <= 1'b0;
      end else if (tick) begin
         leds      <= next_leds;
         dir_right <= next_dir;
         drain     <= next_drain;
         cnt       <= RELOAD;
         step      <= 1'b1;
      end else begin
         cnt  <= cnt - CW'(1);
         step <= 1'b0;
      end
   end

endmodule
